// File: rtl/desired_drive_pipe.sv
// desired_drive_pipe: turns pedal torque, cadence, incline and assist level
// into a target motor current. The current is optionally slew-limited.
// Stages: factor conditioning -> two-cycle product -> saturate/slew/output.
// A sample taken at edge N appears with out_vld after edge N+3.
module desired_drive_pipe #(
  parameter int unsigned          TORQUE_W   = 12,
  parameter int unsigned          OUT_W      = 12,
  parameter logic [TORQUE_W-1:0]  TORQUE_MIN = TORQUE_W'(12'h380),
  parameter logic [OUT_W-1:0]     SLEW_STEP  = OUT_W'(12'h040)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  logic [TORQUE_W-1:0] avg_torque,
  input  logic [4:0]          cadence,
  input  logic                not_pedaling,
  input  logic signed [12:0]  incline,
  input  logic [2:0]          scale,
  input  logic                slew_en,
  output logic                out_vld,
  output logic [OUT_W-1:0]    target_curr
);

  localparam int unsigned INC_W = 9;
  localparam int unsigned CAD_W = 6;
  localparam int unsigned SCL_W = 3;
  localparam int unsigned PA_W  = TORQUE_W + INC_W;
  localparam int unsigned PB_W  = CAD_W + SCL_W;
  localparam int unsigned PW    = PA_W + PB_W;
  localparam int          LSB_W = int'(PW) - 3 - int'(OUT_W);

  // ---------------- stage 1: factor conditioning ----------------
  logic signed [12:0]  inc_sat;
  logic signed [12:0]  inc_off;
  logic [INC_W-1:0]    inc_lim_c;
  logic [CAD_W-1:0]    cad_f_c;
  logic [TORQUE_W-1:0] torque_pos_c;

  logic                v1_q, v1_d;
  logic [INC_W-1:0]    inc_lim_q, inc_lim_d;
  logic [CAD_W-1:0]    cad_f_q, cad_f_d;
  logic [TORQUE_W-1:0] torque_pos_q, torque_pos_d;
  logic                np1_q, np1_d;
  logic [SCL_W-1:0]    scale1_q, scale1_d;
  logic                slew1_q, slew1_d;

  // Saturate incline to 10-bit signed, offset by 256 and clip into 0..511.
  always_comb begin
    inc_sat = incline;
    if (incline > 13'sd511) begin
      inc_sat = 13'sd511;
    end else if (incline < -13'sd512) begin
      inc_sat = -13'sd512;
    end
    inc_off = inc_sat + 13'sd256;
    if (inc_off < 13'sd0) begin
      inc_lim_c = '0;
    end else if (inc_off > 13'sd511) begin
      inc_lim_c = 9'd511;
    end else begin
      inc_lim_c = inc_off[INC_W-1:0];
    end
  end

  // Cadence and torque factors; both are zero below their thresholds.
  always_comb begin
    cad_f_c = '0;
    if (cadence > 5'd1) begin
      cad_f_c = CAD_W'(cadence) + 6'd32;
    end
    torque_pos_c = '0;
    if (avg_torque > TORQUE_MIN) begin
      torque_pos_c = avg_torque - TORQUE_MIN;
    end
  end

  // Stage 1 next state: capture factors only on valid samples.
  always_comb begin
    v1_d         = in_vld;
    inc_lim_d    = inc_lim_q;
    cad_f_d      = cad_f_q;
    torque_pos_d = torque_pos_q;
    np1_d        = np1_q;
    scale1_d     = scale1_q;
    slew1_d      = slew1_q;
    if (in_vld) begin
      inc_lim_d    = inc_lim_c;
      cad_f_d      = cad_f_c;
      torque_pos_d = torque_pos_c;
      np1_d        = not_pedaling;
      scale1_d     = scale;
      slew1_d      = slew_en;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      inc_lim_q    <= '0;
      cad_f_q      <= '0;
      torque_pos_q <= '0;
      np1_q        <= 1'b0;
      scale1_q     <= '0;
      slew1_q      <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      inc_lim_q    <= inc_lim_d;
      cad_f_q      <= cad_f_d;
      torque_pos_q <= torque_pos_d;
      np1_q        <= np1_d;
      scale1_q     <= scale1_d;
      slew1_q      <= slew1_d;
    end
  end

  // ---------------- stage 2a: partial products ----------------
  logic            va_q, va_d;
  logic [PA_W-1:0] pa_q, pa_d;
  logic [PB_W-1:0] pb_q, pb_d;
  logic            npa_q, npa_d;
  logic            slewa_q, slewa_d;

  // Split the four-way product into torque*incline and cadence*scale.
  always_comb begin
    va_d    = v1_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    npa_d   = npa_q;
    slewa_d = slewa_q;
    if (v1_q) begin
      pa_d    = PA_W'(torque_pos_q) * PA_W'(inc_lim_q);
      pb_d    = PB_W'(cad_f_q) * PB_W'(scale1_q);
      npa_d   = np1_q;
      slewa_d = slew1_q;
    end
  end

  // Stage 2a registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va_q    <= 1'b0;
      pa_q    <= '0;
      pb_q    <= '0;
      npa_q   <= 1'b0;
      slewa_q <= 1'b0;
    end else begin
      va_q    <= va_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      npa_q   <= npa_d;
      slewa_q <= slewa_d;
    end
  end

  // ---------------- stage 2b: full product ----------------
  logic          v2_q, v2_d;
  logic [PW-1:0] prod_q, prod_d;
  logic          np2_q, np2_d;
  logic          slew2_q, slew2_d;

  // Final product, forced to zero when the rider is not pedaling.
  always_comb begin
    v2_d    = va_q;
    prod_d  = prod_q;
    np2_d   = np2_q;
    slew2_d = slew2_q;
    if (va_q) begin
      prod_d  = npa_q ? '0 : PW'(pa_q) * PW'(pb_q);
      np2_d   = npa_q;
      slew2_d = slewa_q;
    end
  end

  // Stage 2b registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      prod_q  <= '0;
      np2_q   <= 1'b0;
      slew2_q <= 1'b0;
    end else begin
      v2_q    <= v2_d;
      prod_q  <= prod_d;
      np2_q   <= np2_d;
      slew2_q <= slew2_d;
    end
  end

  // Product LSBs below the output window are intentionally discarded.
  generate
    if (LSB_W > 0) begin : g_lsb
      logic unused_prod_lsb;
      assign unused_prod_lsb = ^prod_q[LSB_W-1:0];
    end
  endgenerate

  // ---------------- stage 3: saturate, slew, output ----------------
  logic [OUT_W-1:0] raw_c;
  logic [OUT_W:0]   up_sum;
  logic [OUT_W-1:0] up_lim;
  logic [OUT_W-1:0] dn_lim;
  logic [OUT_W-1:0] slewed_c;

  logic             out_vld_q, out_vld_d;
  logic [OUT_W-1:0] target_q, target_d;

  // Saturate the product into the output window.
  always_comb begin
    raw_c = prod_q[PW-4 -: OUT_W];
    if (|prod_q[PW-1 -: 3]) begin
      raw_c = '1;
    end
  end

  // Clamp the new value to within one step of the current output, no wrap.
  always_comb begin
    up_sum = {1'b0, target_q} + {1'b0, SLEW_STEP};
    up_lim = up_sum[OUT_W] ? '1 : up_sum[OUT_W-1:0];
    dn_lim = (target_q > SLEW_STEP) ? (target_q - SLEW_STEP) : '0;
    if (raw_c > up_lim) begin
      slewed_c = up_lim;
    end else if (raw_c < dn_lim) begin
      slewed_c = dn_lim;
    end else begin
      slewed_c = raw_c;
    end
  end

  // Output update; not pedaling bypasses the limiter so current drops at once.
  always_comb begin
    out_vld_d = v2_q;
    target_d  = target_q;
    if (v2_q) begin
      target_d = (slew2_q && !np2_q) ? slewed_c : raw_c;
    end
  end

  // Output registers; target_q doubles as the slew reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      target_q  <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      target_q  <= target_d;
    end
  end

  assign out_vld     = out_vld_q;
  assign target_curr = target_q;

endmodule

// File: tb/tb_desired_drive_pipe.sv
// Scoreboard bench for desired_drive_pipe at default parameters.
module tb_desired_drive_pipe;

  logic               clk;
  logic               rst_n;
  logic               in_vld;
  logic [11:0]        avg_torque;
  logic [4:0]         cadence;
  logic               not_pedaling;
  logic signed [12:0] incline;
  logic [2:0]         scale;
  logic               slew_en;
  logic               out_vld;
  logic [11:0]        target_curr;

  desired_drive_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .avg_torque   (avg_torque),
    .cadence      (cadence),
    .not_pedaling (not_pedaling),
    .incline      (incline),
    .scale        (scale),
    .slew_en      (slew_en),
    .out_vld      (out_vld),
    .target_curr  (target_curr)
  );

  typedef struct {
    logic [11:0] val;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] model_ref = '0;
  logic [11:0] exp_hold = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference model written directly from the arithmetic definition.
  function automatic logic [11:0] model(input logic [11:0] tq, input logic [4:0] cad,
                                        input logic np, input logic [12:0] inc,
                                        input logic [2:0] sc, input logic sl,
                                        input logic [11:0] ref_v);
    int incs, lim, cf, tp, raw, outv, up, dn;
    longint prod;
    incs = int'($signed(inc));
    if (incs > 511) incs = 511;
    if (incs < -512) incs = -512;
    lim = incs + 256;
    if (lim < 0) lim = 0;
    if (lim > 511) lim = 511;
    cf = (int'(cad) > 1) ? int'(cad) + 32 : 0;
    tp = (int'(tq) > 'h380) ? int'(tq) - 'h380 : 0;
    prod = np ? 64'sd0 : longint'(tp) * longint'(lim) * longint'(cf) * longint'(sc);
    raw = (prod >= 64'sd134217728) ? 4095 : int'(prod >>> 15);
    if (!sl || np) begin
      outv = raw;
    end else begin
      up = int'(ref_v) + 'h40;
      if (up > 4095) up = 4095;
      dn = int'(ref_v) - 'h40;
      if (dn < 0) dn = 0;
      outv = (raw > up) ? up : ((raw < dn) ? dn : raw);
    end
    return 12'(outv);
  endfunction

  task automatic send(input logic [11:0] tq, input logic [4:0] cad, input logic np,
                      input logic [12:0] inc, input logic [2:0] sc, input logic sl);
    exp_t e;
    @(posedge clk); #1;
    in_vld = 1'b1; avg_torque = tq; cadence = cad; not_pedaling = np;
    incline = inc; scale = sc; slew_en = sl;
    e.val = model(tq, cad, np, inc, sc, sl, model_ref);
    e.due = cyc + 4;
    model_ref = e.val;
    sb.push_back(e);
  endtask

  task automatic nominal(input logic sl);
    send(12'h500, 5'd10, 1'b0, 13'd0, 3'd3, sl);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    in_vld = 1'b0;
    exp_hold = '0;
    model_ref = '0;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_target", 32'(target_curr), 32'd0);
    rst_n = 1'b1;
  endtask

  // Output monitor: pops the scoreboard on out_vld, checks hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() != 0 && cyc > sb[0].due) begin
        chk("missing_out_vld", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (out_vld === 1'b1) begin
        if (sb.size() == 0) begin
          chk("stray_out_vld", 32'(out_vld), 32'd0);
        end else begin
          chk("latency", 32'(cyc), 32'(sb[0].due));
          chk("target_curr", 32'(target_curr), 32'(sb[0].val));
          exp_hold = sb[0].val;
          void'(sb.pop_front());
        end
      end else begin
        chk("out_vld_known", 32'(out_vld), 32'd0);
        chk("target_hold", 32'(target_curr), 32'(exp_hold));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; avg_torque = '0; cadence = '0; not_pedaling = 1'b0;
    incline = '0; scale = '0; slew_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_vld", 32'(out_vld), 32'd0);
    chk("reset_target", 32'(target_curr), 32'd0);
    rst_n = 1'b1;

    // Nominal sample: 0x17A after three edges.
    nominal(1'b0);
    drain();

    // Saturation, including an out-of-range positive incline.
    send(12'hFFF, 5'd31, 1'b0, 13'd511, 3'd7, 1'b0);
    send(12'hFFF, 5'd31, 1'b0, 13'h0FFF, 3'd7, 1'b0);
    drain();

    // Zero cases back to back.
    send(12'h500, 5'd1, 1'b0, 13'd0, 3'd3, 1'b0);
    send(12'h500, 5'd10, 1'b0, -13'sd300, 3'd3, 1'b0);
    send(12'h37F, 5'd10, 1'b0, 13'd0, 3'd3, 1'b0);
    send(12'h500, 5'd10, 1'b0, 13'd0, 3'd0, 1'b0);
    drain();

    // Slew ramp from reset, then an unlimited drop on not_pedaling.
    do_reset();
    for (int i = 0; i < 6; i++) nominal(1'b1);
    send(12'h500, 5'd10, 1'b1, 13'd0, 3'd3, 1'b1);
    drain();

    // Interleaved nominal/zero stream with random single-cycle gaps.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) nominal(1'($urandom_range(0, 1)));
      else send(12'h500, 5'd1, 1'b0, 13'd0, 3'd3, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle();
    end
    drain();

    // Reset with three samples in flight: none may emerge afterwards.
    send(12'h600, 5'd20, 1'b0, 13'd100, 3'd5, 1'b0);
    send(12'hFFF, 5'd31, 1'b0, 13'd511, 3'd7, 1'b0);
    nominal(1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", 32'(out_vld), 32'd0);
    end

    // First sample after release slews from zero.
    nominal(1'b1);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
